// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: opcodes, ALU selects, FSM states and instruction field positions
package instr_sequencer_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSA = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPREAD = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 10;
  localparam int SA_HI  = 9;
  localparam int SA_LO  = 8;
  localparam int SB_HI  = 7;
  localparam int SB_LO  = 6;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational instruction classification and ALU function select
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output logic        writes_reg,
  output logic        is_ldi,
  output logic        is_jmp,
  output logic        is_jz,
  output logic        is_hlt,
  output logic [2:0]  alu_op
);
  logic [3:0] op;
  assign op = ir[OP_HI:OP_LO];
  always_comb begin
    writes_reg = (op >= OP_LDI) && (op <= OP_MOV);
    is_ldi = op == OP_LDI;
    is_jmp = op == OP_JMP;
    is_jz  = op == OP_JZ;
    is_hlt = op == OP_HLT;
    alu_op = op == OP_SUB ? ALU_SUB :
             op == OP_AND ? ALU_AND :
             op == OP_OR  ? ALU_OR  :
             op == OP_XOR ? ALU_XOR :
             (op == OP_MOV || op == OP_JZ) ? ALU_PASSA : ALU_ADD;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: 5-cycle fetch/decode/read/exec/writeback control stage for a 4-entry register file
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int IW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] rom_addr,
  input  logic [IW-1:0]   rom_data,
  input  logic [7:0]      alu_y,
  input  logic            alu_z,
  output logic [7:0]      D,
  output logic [1:0]      addr,
  output logic            WE,
  output logic [1:0]      cha,
  output logic [1:0]      chb,
  output logic [2:0]      alu_op,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] pc
);
  state_t          st;
  logic [IW-1:0]   ir;
  logic [7:0]      res;
  logic            zf;
  logic            wr, ldi, jmp, jz, hlt;
  logic [PC_W-1:0] pc_nx;

  instr_decode u_dec (
    .ir(ir),
    .writes_reg(wr),
    .is_ldi(ldi),
    .is_jmp(jmp),
    .is_jz(jz),
    .is_hlt(hlt),
    .alu_op(alu_op)
  );

  assign pc_nx = (jmp || (jz && zf)) ? PC_W'(ir[IMM_HI:IMM_LO]) : pc + 1'b1;

  // rom_addr is loaded on entry to FETCH so the ROM sees it during FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      pc <= '0;
      rom_addr <= '0;
      ir <= '0;
      res <= '0;
      zf <= 1'b0;
    end else begin
      case (st)
        S_IDLE: if (run) begin
          st <= S_FETCH;
          rom_addr <= pc;
        end
        S_FETCH: begin
          rom_addr <= pc;
          st <= S_DECODE;
        end
        S_DECODE: begin
          ir <= rom_data;
          st <= S_OPREAD;
        end
        S_OPREAD: st <= S_EXEC;
        S_EXEC: begin
          res <= alu_y;
          zf <= alu_z;
          st <= S_WB;
        end
        S_WB: if (hlt) st <= S_HALT;
        else begin
          pc <= pc_nx;
          rom_addr <= pc_nx;
          st <= S_FETCH;
        end
        default: st <= st;
      endcase
    end
  end

  assign D      = ldi ? ir[IMM_HI:IMM_LO] : res;
  assign addr   = ir[DST_HI:DST_LO];
  assign WE     = (st == S_WB) && wr;
  assign cha    = ir[SA_HI:SA_LO];
  assign chb    = ir[SB_HI:SB_LO];
  assign busy   = !(st == S_IDLE || st == S_HALT);
  assign halted = st == S_HALT;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed programs against ROM, register-file and ALU models
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  alu_y;
  logic        alu_z;
  logic [7:0]  D;
  logic [1:0]  addr;
  logic        WE;
  logic [1:0]  cha, chb;
  logic [2:0]  alu_op;
  logic        busy, halted;
  logic [7:0]  pc;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_y(alu_y), .alu_z(alu_z), .D(D), .addr(addr), .WE(WE), .cha(cha), .chb(chb),
    .alu_op(alu_op), .busy(busy), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [7:0]  rf [4];
  logic [1:0]  sa_q, sb_q;
  logic [7:0]  da, db;

  always @(posedge clk) begin
    rom_data <= rom[rom_addr];
    sa_q <= cha;
    sb_q <= chb;
    if (WE) rf[addr] <= D;
  end

  assign da = rf[sa_q];
  assign db = rf[sb_q];
  assign alu_y = alu_op == 3'd0 ? da + db :
                 alu_op == 3'd1 ? da - db :
                 alu_op == 3'd2 ? (da & db) :
                 alu_op == 3'd3 ? (da | db) :
                 alu_op == 3'd4 ? (da ^ db) :
                 alu_op == 3'd5 ? da : 8'h00;
  assign alu_z = alu_y == 8'h00;

  int nc = 0;
  int wc[$];
  int wa[$];
  int wd[$];
  logic [2:0] aop_h [4096];
  logic [7:0] ra_h [4096];

  always @(posedge clk) nc <= nc + 1;

  always @(negedge clk) begin
    aop_h[nc[11:0]] = alu_op;
    ra_h[nc[11:0]] = rom_addr;
    if (WE) begin
      wc.push_back(nc + 1);
      wa.push_back(int'(addr));
      wd.push_back(int'(D));
    end
  end

  int nv = 0;
  int nf = 0;
  int t0 = 0;
  int n0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nv++;
    if (got !== exp) begin
      nf++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] p0, input logic [15:0] p1,
                      input logic [15:0] p2, input logic [15:0] p3);
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    rom[0] = p0;
    rom[1] = p1;
    rom[2] = p2;
    rom[3] = p3;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n0 = wc.size();
  endtask

  task automatic go();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    t0 = nc;
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
    chk("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic chkw(input int i, input int cyc, input int a, input int d);
    chk($sformatf("wr%0d_cyc", i), 32'(wc[n0+i] - t0), 32'(cyc));
    chk($sformatf("wr%0d_addr", i), 32'(wa[n0+i]), 32'(a));
    chk($sformatf("wr%0d_d", i), 32'(wd[n0+i]), 32'(d));
  endtask

  initial begin
    load(16'h1405, 16'h1807, 16'h2D80, 16'hF000);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    do_rst();
    // reset during a writeback cycle must kill WE at once
    go();
    repeat (4) @(negedge clk);
    chk("wb_we", 32'(WE), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(WE), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rom_addr", 32'(rom_addr), 32'd0);
    chk("idle_nowrite", 32'(wc.size() - n0), 32'd1);

    load(16'h1405, 16'h1807, 16'h2D80, 16'hF000);
    do_rst();
    go();
    wait_halt();
    chk("ldi_nw", 32'(wc.size() - n0), 32'd3);
    if (wc.size() - n0 >= 3) begin
      chkw(0, 5, 1, 8'h05);
      chkw(1, 10, 2, 8'h07);
      chkw(2, 15, 3, 8'h0C);
    end
    chk("ldi_pc", 32'(pc), 32'd3);
    chk("ldi_busy", 32'(busy), 32'd0);

    load(16'h1403, 16'h1805, 16'h3180, 16'hF000);
    do_rst();
    go();
    wait_halt();
    chk("sub_nw", 32'(wc.size() - n0), 32'd3);
    if (wc.size() - n0 >= 3) chkw(2, 15, 0, 8'hFE);
    chk("sub_aluop", 32'(aop_h[12'(t0 + 13)]), 32'd1);

    load(16'h1400, 16'h9120, 16'hF000, 16'hF000);
    do_rst();
    go();
    wait_halt();
    chk("jz_t_pc", 32'(pc), 32'h20);
    chk("jz_t_nw", 32'(wc.size() - n0), 32'd1);
    chk("jz_aluop", 32'(aop_h[12'(t0 + 8)]), 32'd5);

    load(16'h1401, 16'h9120, 16'hF000, 16'hF000);
    rom[8'h20] = 16'h0000;
    do_rst();
    go();
    wait_halt();
    chk("jz_n_pc", 32'(pc), 32'd2);
    chk("jz_n_nw", 32'(wc.size() - n0), 32'd1);

    load(16'h80FF, 16'hF000, 16'hF000, 16'hF000);
    rom[8'hFF] = 16'h0000;
    do_rst();
    go();
    repeat (12) @(negedge clk);
    chk("jmp_fetch_ff", 32'(ra_h[12'(t0 + 5)]), 32'hFF);
    chk("wrap_fetch_00", 32'(ra_h[12'(t0 + 10)]), 32'h00);
    chk("wrap_pc", 32'(pc), 32'h00);

    load(16'hB000, 16'hF000, 16'hF000, 16'hF000);
    do_rst();
    go();
    wait_halt();
    chk("undef_pc", 32'(pc), 32'd1);
    chk("undef_nw", 32'(wc.size() - n0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      run = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("hlt_sticky", 32'(halted), 32'd1);
    chk("hlt_pc", 32'(pc), 32'd1);
    chk("hlt_busy", 32'(busy), 32'd0);
    chk("hlt_nw", 32'(wc.size() - n0), 32'd0);
    do_rst();
    chk("hlt_cleared", 32'(halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end
endmodule
